// File: rtl/mux_out_fifo_if.sv
// Handshake/bus bundle between the lane-mux side, mux_out_fifo and its consumer.
// The err signal exists only when FIFO_ERR_EN is defined.
interface mux_out_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
`ifdef FIFO_ERR_EN
    logic              err;
`endif

    // master: the environment driving pushes/pops; slave: the FIFO itself
    modport master (
        output data_in, valid_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, count
`ifdef FIFO_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  data_in, valid_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty, count
`ifdef FIFO_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/mux_out_fifo.sv
// Elastic FIFO behind the 2:1 lane mux: registered read, no fall-through, occupancy flags.
// Define FIFO_ERR_EN to add a sticky overflow/underflow err output.
module mux_out_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AF_THR = 3,
    parameter int AE_THR = 1
) (
    input  logic            f2,
    input  logic            reset,
    mux_out_fifo_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] data_out_reg;
    logic              valid_out_reg;

    logic full_flag;
    logic empty_flag;
    logic push_ok;
    logic pop_ok;

    assign full_flag  = (count_reg == CNT_W'(DEPTH));
    assign empty_flag = (count_reg == '0);

    // A full FIFO still takes a push when the same edge pops; an empty one never fall-throughs.
    assign pop_ok  = bus.pop && !empty_flag;
    assign push_ok = bus.valid_in && (!full_flag || bus.pop);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge f2) begin
        if (push_ok && !reset) begin
            mem[wr_ptr_reg] <= bus.data_in;
        end
    end

    always_ff @(posedge f2) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            valid_out_reg <= pop_ok;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                data_out_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

`ifdef FIFO_ERR_EN
    logic err_reg;

    always_ff @(posedge f2) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if ((bus.valid_in && full_flag && !bus.pop) || (bus.pop && empty_flag)) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err = err_reg;
`endif

    assign bus.data_out     = data_out_reg;
    assign bus.valid_out    = valid_out_reg;
    assign bus.count        = count_reg;
    assign bus.full         = full_flag;
    assign bus.empty        = empty_flag;
    assign bus.almost_full  = (count_reg >= CNT_W'(AF_THR));
    assign bus.almost_empty = (count_reg <= CNT_W'(AE_THR));
endmodule
